// File: rtl/vga_pkg.sv
// vga_pkg: 720p timing constants, derived sync windows and shared types
// for the pixel pipeline (timing generator and the draw_* stages).
package vga_pkg;

  localparam int COUNT_W = 11;
  localparam int FRAME_CNT_W = 16;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HSYNC_START = H_ACTIVE + H_FP;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
  localparam int VSYNC_START = V_ACTIVE + V_FP;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

  // Run control: HOLD is the single cycle after reset release in which the
  // (0,0) tuple is presented with frame_start before counting begins.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: timing tuple driven by the generator (master) and
// consumed by the first draw stage (slave). There is no handshake: the
// tuple is valid on every pclk edge and the sink can never stall it.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [COUNT_W-1:0] hcount;
  logic [COUNT_W-1:0] vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;
  logic               frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
`endif
  run_state_t         state;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output frame_cnt,
`endif
    output state
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    input frame_cnt,
`endif
    input state
  );
endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-(MAX+1) counter advancing when inc is high. Exposes
// the next-state value so callers can register flags aligned with count.
module wrap_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 1649
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Next value: wrap to zero at MAX, otherwise add inc.
  always_comb begin
    wrap      = inc && (count == MAX_V);
    count_nxt = wrap ? '0 : count + {{(WIDTH-1){1'b0}}, inc};
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!rst) count <= '0;
    else      count <= count_nxt;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 720p60 timing source. All outputs are
// registered from the next-state counters so the tuple is never skewed.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int   H_FP      = vga_pkg::H_FP,
  parameter int   H_SYNC    = vga_pkg::H_SYNC,
  parameter int   H_BP      = vga_pkg::H_BP,
  parameter int   V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int   V_FP      = vga_pkg::V_FP,
  parameter int   V_SYNC    = vga_pkg::V_SYNC,
  parameter int   V_BP      = vga_pkg::V_BP,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic              pclk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);
  import vga_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COUNT_W-1:0] HA_C  = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] VA_C  = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] HS0_C = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] HS1_C = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VS0_C = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] VS1_C = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Totals must fit the 11-bit counters; refuse to elaborate otherwise.
  if (H_TOTAL > (1 << COUNT_W) - 1 || V_TOTAL > (1 << COUNT_W) - 1) begin : g_size_check
    $error("vga_timing_gen: H/V total exceeds counter range");
  end

  run_state_t         state_q, state_d;
  logic [COUNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic               h_wrap, v_wrap, run;

  // Run-control register.
  always_ff @(posedge pclk) begin
    if (!rst) state_q <= ST_HOLD;
    else      state_q <= state_d;
  end

  // HOLD lasts exactly one cycle, then the counters run forever.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_HOLD) state_d = ST_RUN;
  end

  assign run = (state_q == ST_RUN);

  wrap_counter #(.WIDTH(COUNT_W), .MAX(H_TOTAL - 1)) u_hcnt (
    .pclk(pclk), .rst(rst), .inc(run),
    .count(h_cnt), .count_nxt(h_nxt), .wrap(h_wrap)
  );

  wrap_counter #(.WIDTH(COUNT_W), .MAX(V_TOTAL - 1)) u_vcnt (
    .pclk(pclk), .rst(rst), .inc(h_wrap),
    .count(v_cnt), .count_nxt(v_nxt), .wrap(v_wrap)
  );

  // Flags registered from next-state counters; a frame starts either on a
  // vertical wrap or on leaving HOLD.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      vga.hblnk       <= 1'b0;
      vga.vblnk       <= 1'b0;
      vga.hsync       <= ~HSYNC_POL;
      vga.vsync       <= ~VSYNC_POL;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hblnk       <= (h_nxt >= HA_C);
      vga.vblnk       <= (v_nxt >= VA_C);
      vga.hsync       <= (h_nxt >= HS0_C && h_nxt <= HS1_C) ? HSYNC_POL : ~HSYNC_POL;
      vga.vsync       <= (v_nxt >= VS0_C && v_nxt <= VS1_C) ? VSYNC_POL : ~VSYNC_POL;
      vga.frame_start <= v_wrap || (state_q == ST_HOLD);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter: bumps on vertical wrap only, so the first frame stays 0.
  always_ff @(posedge pclk) begin
    if (!rst)        vga.frame_cnt <= '0;
    else if (v_wrap) vga.frame_cnt <= vga.frame_cnt + 1'b1;
  end
`endif

  assign vga.hcount = h_cnt;
  assign vga.vcount = v_cnt;
  assign vga.state  = state_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Source end of the pixel-pipeline timing interface. Generates hcount/vcount, hsync/vsync and hblnk/vblnk for 1280x720@60 (CEA 720p) and feeds them to the first stage of the draw chain (background, then sprites, then VGA pins). All outputs are registered and mutually aligned, so every downstream stage receives a coherent tuple on each pclk edge.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels); line total 1650
V_ACTIVE, 720, visible lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines); frame total 750
HSYNC_POL, 1, hsync active level (1 = active-high)
VSYNC_POL, 1, vsync active level

Ports:
pclk  in  1  pixel clock, 74.25 MHz
rst  in  1  synchronous, active-low reset
vcount  out  11  line index 0..749
vsync  out  1  vertical sync at VSYNC_POL level
vblnk  out  1  high for vcount >= V_ACTIVE
hcount  out  11  pixel index 0..1649
hsync  out  1  horizontal sync at HSYNC_POL level
hblnk  out  1  high for hcount >= H_ACTIVE
frame_start  out  1  one-pclk pulse, high when hcount==0 && vcount==0

Behaviour:
- Reset is one clock, single domain, sampled only on rising pclk while rst==0. Reset values: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, frame_start=0.
- First cycle after rst goes high: outputs still show the (0,0) tuple and frame_start=1. Counting then advances one pixel per pclk.
- hcount: increments by 1 and wraps from H_TOT-1 (1649) to 0. vcount increments only on the cycle hcount wraps, and wraps from V_TOT-1 (749) to 0 on that same edge.
- Derived signals are computed from the next-state counters and registered together with them. The tuple is never skewed; latency from counter to flag is 0 cycles.
- hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1390,1429].
- vsync is active for vcount in [725,729]. It changes at hcount==0, because it uses full-line granularity.
- hblnk covers 1280..1649; vblnk covers 720..749. Pixels with both flags low are the active area.
- frame_start: high for exactly one cycle per 1650*750 = 1,237,500 cycles.
- Reset asserted mid-frame: the next edge forces the reset tuple regardless of counter position. No partial line completes.
- Counters are sized 11 bits. The block does not elaborate if H_TOT or V_TOT exceeds 2047 (elaboration-time check).
- No enable input; the block free-runs.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN:
- Defined: adds output frame_cnt [15:0]. It resets to 0 and increments on the same edge that frame_start is driven high, except the first frame after reset, which stays 0. It wraps at 65535 to 0. Intended for animation and game-tick logic.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - the 720p timing constants (H_ACTIVE..V_BP, H_TOT, V_TOT);
  - the derived window bounds (HSYNC_START/END, VSYNC_START/END);
  - COUNT_W = 11.
  - draw_* stages import the same package for screen dimensions.
- One natural sub-module, wrap_counter (parameters WIDTH, MAX; inputs pclk, rst, inc; outputs count, wrap). It is instantiated twice: horizontal with inc=1, vertical with inc=h_wrap.

Test Plan:
- Reset release: hold rst=0 for 5 cycles, then release. The first sampled tuple is (h=0,v=0,hblnk=0,vblnk=0,hsync=0,vsync=0) with frame_start=1; on the next cycle h=1 and frame_start=0.
- Line timing: count cycles over one line. hblnk rises at h=1280; hsync is high for h=1390..1429 (40 cycles); h wraps 1649->0 and v increments on the same edge.
- Frame timing: run 1,237,500 cycles. vblnk rises at v=720, vsync is high for v=725..729 (5 full lines), v wraps 749->0, and frame_start pulses exactly twice, 1,237,500 cycles apart.
- Mid-frame reset: assert rst at h=700, v=300 for 1 cycle. The next tuple is the reset tuple and counting restarts from (0,0). A scoreboard checks there is no glitch on hsync/vsync.
- Polarity: instantiate with HSYNC_POL=0, VSYNC_POL=0. hsync is low only for h=1390..1429, vsync is low only for v=725..729, and both idle high after reset.
- With VGA_TIMING_FRAME_CNT_EN: frame_cnt reads 0,1,2 across three frame_start pulses. Force-preload 65535; it wraps to 0 on the next frame_start.
